// File: rtl/sprite_pixel_renderer.sv
// Sprite pixel renderer: composes pacman and four ghosts over a flat background
// for each visible raster position, with a fixed two-cycle latency.
// Positions and direction are captured into shadow registers on frame_start so
// a frame never tears. A death flash and an optional mouth animation modulate
// pacman. Define SPRITE_PIXEL_RENDERER_MOUTH_ANIM_EN to animate the mouth;
// without it the mouth stays open.

// Per-sprite S1 stage: bounding-box hit and in-sprite offsets.
module sprite_pixel_renderer_hit #(
  parameter int SIZE_LOG2 = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [10:0]          pixel_x,
  input  logic [9:0]           pixel_y,
  input  logic [10:0]          pos_x,
  input  logic [9:0]           pos_y,
  output logic                 hit,
  output logic [SIZE_LOG2-1:0] ox,
  output logic [SIZE_LOG2-1:0] oy
);
  // One extra bit so a sprite near the right/bottom edge clips instead of wrapping.
  logic [11:0] px, lo_x, hi_x;
  logic [10:0] py, lo_y, hi_y;
  logic        hit_c;

  assign px    = {1'b0, pixel_x};
  assign lo_x  = {1'b0, pos_x};
  assign hi_x  = lo_x + 12'(1 << SIZE_LOG2);
  assign py    = {1'b0, pixel_y};
  assign lo_y  = {1'b0, pos_y};
  assign hi_y  = lo_y + 11'(1 << SIZE_LOG2);
  assign hit_c = (px >= lo_x) && (px < hi_x) && (py >= lo_y) && (py < hi_y);

  // Register hit and offsets; offsets only matter when hit is set.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hit <= 1'b0;
      ox  <= '0;
      oy  <= '0;
    end else begin
      hit <= hit_c;
      ox  <= pixel_x[SIZE_LOG2-1:0] - pos_x[SIZE_LOG2-1:0];
      oy  <= pixel_y[SIZE_LOG2-1:0] - pos_y[SIZE_LOG2-1:0];
    end
  end
endmodule

module sprite_pixel_renderer #(
  parameter int          SIZE_LOG2          = 4,
  parameter int          DEATH_FLASH_FRAMES = 8,
  parameter int          MOUTH_FRAMES       = 4,
  parameter logic [11:0] BG_COLOR           = 12'h000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  input  logic        pixel_valid,
  input  logic [10:0] pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic [10:0] pacman_pos_x,
  input  logic [9:0]  pacman_pos_y,
  input  logic [10:0] blinky_pos_x,
  input  logic [9:0]  blinky_pos_y,
  input  logic [10:0] pinky_pos_x,
  input  logic [9:0]  pinky_pos_y,
  input  logic [10:0] inky_pos_x,
  input  logic [9:0]  inky_pos_y,
  input  logic [10:0] clyde_pos_x,
  input  logic [9:0]  clyde_pos_y,
  input  logic [3:0]  pacman_dir,
  input  logic        pacman_is_dead,
  output logic [11:0] rgb,
  output logic        rgb_valid,
  output logic        sprite_hit
);
  localparam int NUM_SPR = 5;  // index 0 = pacman, then ghosts in priority order
  localparam int STAGES  = 2;
  localparam int SW      = SIZE_LOG2;
  localparam logic [SW-1:0] CTR   = SW'(1 << (SW - 1));
  localparam logic [SW-1:0] EDGE  = SW'((1 << SW) - 2);
  localparam logic [7:0]    FLAST = 8'(DEATH_FLASH_FRAMES - 1);
  localparam logic [NUM_SPR-1:0][11:0] SPR_COL =
    {12'hFA0, 12'h0FF, 12'hFBD, 12'hF00, 12'hFF0};

  typedef enum logic {NORMAL, FLASH} state_t;

  logic [NUM_SPR-1:0][10:0] in_x, sh_x;
  logic [NUM_SPR-1:0][9:0]  in_y, sh_y;
  logic [3:0]               sh_dir, s1_dir;
  logic [NUM_SPR-1:0]       s1_hit;
  logic [NUM_SPR-1:0][SW-1:0] s1_ox, s1_oy;
  logic [STAGES:1]          vld_pipe;
  state_t                   state;
  logic [7:0]               flash_cnt;
  logic                     dead_d;
  logic                     mouth_open;

  assign in_x = {clyde_pos_x, inky_pos_x, pinky_pos_x, blinky_pos_x, pacman_pos_x};
  assign in_y = {clyde_pos_y, inky_pos_y, pinky_pos_y, blinky_pos_y, pacman_pos_y};

  // Shadow latch; a zero direction leaves the last real direction in place.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sh_x   <= '0;
      sh_y   <= '0;
      sh_dir <= '0;
    end else if (frame_start) begin
      sh_x <= in_x;
      sh_y <= in_y;
      if (pacman_dir != 4'b0000) sh_dir <= pacman_dir;
    end
  end

  for (genvar i = 0; i < NUM_SPR; i++) begin : g_spr
    sprite_pixel_renderer_hit #(.SIZE_LOG2(SIZE_LOG2)) u_hit (
      .clk     (clk),
      .rst     (rst),
      .pixel_x (pixel_x),
      .pixel_y (pixel_y),
      .pos_x   (sh_x[i]),
      .pos_y   (sh_y[i]),
      .hit     (s1_hit[i]),
      .ox      (s1_ox[i]),
      .oy      (s1_oy[i])
    );
  end

  // Valid shift register plus the direction that belongs to the S1 pixel.
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_pipe <= '0;
      s1_dir   <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], pixel_valid};
      s1_dir   <= sh_dir;
    end
  end

  // Death flash FSM; extra death edges while flashing are ignored.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= NORMAL;
      flash_cnt <= '0;
      dead_d    <= 1'b0;
    end else begin
      dead_d <= pacman_is_dead;
      if (state == NORMAL) begin
        if (pacman_is_dead && !dead_d) begin
          state     <= FLASH;
          flash_cnt <= '0;
        end
      end else if (frame_start) begin
        if (flash_cnt == FLAST) begin
          state     <= NORMAL;
          flash_cnt <= '0;
        end else begin
          flash_cnt <= flash_cnt + 8'd1;
        end
      end
    end
  end

`ifdef SPRITE_PIXEL_RENDERER_MOUTH_ANIM_EN
  logic [7:0] mouth_cnt;
  // Mouth phase: toggle every MOUTH_FRAMES frames.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mouth_cnt  <= '0;
      mouth_open <= 1'b1;
    end else if (frame_start) begin
      if (mouth_cnt == 8'(MOUTH_FRAMES - 1)) begin
        mouth_cnt  <= '0;
        mouth_open <= ~mouth_open;
      end else begin
        mouth_cnt <= mouth_cnt + 8'd1;
      end
    end
  end
`else
  assign mouth_open = 1'b1;
`endif

  // S2 combinational: masks, flash, priority mux.
  logic [SW-1:0] u, v, dv, du;
  logic          wedge, pac_vis, hit_c;
  logic [11:0]   col_c;

  // Rotate/mirror offsets so the wedge test is always written for RIGHT.
  always_comb begin
    u = s1_ox[0];
    v = s1_oy[0];
    if (s1_dir == 4'b0000 || s1_dir[0]) begin
      u = s1_ox[0];  v = s1_oy[0];
    end else if (s1_dir[1]) begin
      u = ~s1_oy[0]; v = s1_ox[0];
    end else if (s1_dir[2]) begin
      u = s1_oy[0];  v = s1_ox[0];
    end else begin
      u = ~s1_ox[0]; v = s1_oy[0];
    end
    dv    = (v >= CTR) ? (v - CTR) : (CTR - v);
    du    = u - CTR;
    wedge = mouth_open && (u >= CTR) && (dv <= du);
  end

  // Lowest-priority sprite first so higher ones overwrite.
  always_comb begin
    col_c = BG_COLOR;
    hit_c = 1'b0;
    for (int i = NUM_SPR - 1; i >= 1; i--) begin
      if (s1_hit[i] && !((s1_oy[i] < SW'(2)) && ((s1_ox[i] < SW'(2)) || (s1_ox[i] >= EDGE)))) begin
        col_c = SPR_COL[i];
        hit_c = 1'b1;
      end
    end
    pac_vis = s1_hit[0] && ((state == FLASH) ? flash_cnt[0] : !wedge);
    if (pac_vis) begin
      col_c = (state == FLASH) ? 12'hFFF : SPR_COL[0];
      hit_c = 1'b1;
    end
  end

  // S2 register; output is forced quiet when the pixel is not visible.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rgb        <= '0;
      sprite_hit <= 1'b0;
    end else begin
      rgb        <= vld_pipe[1] ? col_c : 12'h000;
      sprite_hit <= vld_pipe[1] & hit_c;
    end
  end

  assign rgb_valid = vld_pipe[STAGES];
endmodule
